// File: rtl/inst_fetch_unit.sv
// Multicycle instruction fetch stage: word reads over req/ack, instruction
// register presented to decode through valid/ready, with PC redirect support.
module inst_fetch_unit #(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_err,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [6:0]      opcode,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ir_q, ir_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            redir_pend_q, redir_pend_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;
  logic            redir_misaligned;

  // State and datapath registers; reset abandons any outstanding transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      inst_pc_q    <= '0;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      inst_pc_q    <= inst_pc_d;
      redir_pend_q <= redir_pend_d;
      redir_pc_q   <= redir_pc_d;
    end
  end

  assign redir_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);

  // Next-state and datapath updates; redirect beats sequential increment.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    inst_pc_d    = inst_pc_q;
    redir_pend_d = redir_pend_q;
    redir_pc_d   = redir_pc_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (redir_misaligned) begin
          state_d = FAULT;
        end else if (imem_ack && imem_err) begin
          state_d = FAULT;
        end else if (imem_ack && (redir_pend_q || redirect_valid)) begin
          // Acked word belongs to the stale path: drop it and refetch.
          pc_d         = redirect_valid ? redirect_pc : redir_pc_q;
          redir_pend_d = 1'b0;
        end else if (imem_ack) begin
          ir_d      = imem_rdata;
          inst_pc_d = pc_q;
          state_d   = HOLD;
        end else if (redirect_valid) begin
          // Keep the request stable; apply the target once the ack returns.
          redir_pc_d   = redirect_pc;
          redir_pend_d = 1'b1;
        end
      end
      HOLD: begin
        if (redir_misaligned) begin
          state_d = FAULT;
        end else if (redirect_valid) begin
          pc_d = redirect_pc;
          if (inst_ready) state_d = FETCH;
        end else if (inst_ready) begin
          pc_d    = pc_q + XLEN'(4);
          state_d = FETCH;
        end
      end
      FAULT: state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded straight from state and registers.
  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign inst_valid  = (state_q == HOLD);
  assign inst        = ir_q;
  assign inst_pc     = inst_pc_q;
  assign opcode      = inst_valid ? ir_q[6:0] : 7'b0000000;
  assign fetch_fault = (state_q == FAULT);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with hand-computed expectations.
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic        inst_valid;
  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  int n_checks = 0;
  int n_errors = 0;

  inst_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .imem_err       (imem_err),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .opcode         (opcode),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_fault    (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are observed 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] words [3];

  initial begin
    words[0] = 32'h0010_0113;
    words[1] = 32'h0020_0193;
    words[2] = 32'h0000_0033;

    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; imem_err = 1'b0;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    tick(); tick();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_opcode", 32'(opcode), 32'd0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    chk("rst_inst", inst, 32'd0);

    // First fetch with two wait cycles.
    rst = 1'b0;
    tick();
    chk("f0_req", 32'(imem_req), 32'd1);
    chk("f0_addr", imem_addr, 32'h0);
    tick();
    chk("f0_wait1_req", 32'(imem_req), 32'd1);
    tick();
    chk("f0_wait2_addr", imem_addr, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
    tick();
    imem_ack = 1'b0;
    chk("f0_valid", 32'(inst_valid), 32'd1);
    chk("f0_opcode", 32'(opcode), 32'h13);
    chk("f0_inst", inst, 32'h0050_0093);
    chk("f0_pc", inst_pc, 32'h0);
    chk("f0_req_low", 32'(imem_req), 32'd0);

    // Decoder stalls for five cycles.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_inst", inst, 32'h0050_0093);
      chk("hold_opcode", 32'(opcode), 32'h13);
      chk("hold_pc", inst_pc, 32'h0);
      chk("hold_req", 32'(imem_req), 32'd0);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("seq_addr", imem_addr, 32'h4);
    chk("seq_valid", 32'(inst_valid), 32'd0);

    // Redirect while waiting for ack at 0x4: acked word is dropped.
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    chk("pend_addr_stable", imem_addr, 32'h4);
    chk("pend_req_stable", 32'(imem_req), 32'd1);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    chk("drop_valid", 32'(inst_valid), 32'd0);
    chk("drop_addr", imem_addr, 32'h100);
    imem_ack = 1'b1; imem_rdata = 32'h0000_0033;
    tick();
    imem_ack = 1'b0;
    chk("r100_valid", 32'(inst_valid), 32'd1);
    chk("r100_pc", inst_pc, 32'h100);
    chk("r100_opcode", 32'(opcode), 32'h33);

    // Redirect in HOLD without ready stays in HOLD; a later one with ready wins.
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick();
    chk("hredir_valid", 32'(inst_valid), 32'd1);
    chk("hredir_pc", inst_pc, 32'h100);
    redirect_pc = 32'h40; inst_ready = 1'b1;
    tick();
    redirect_valid = 1'b0; inst_ready = 1'b0;
    chk("hredir_req", 32'(imem_req), 32'd1);
    chk("hredir_addr", imem_addr, 32'h40);

    // Reset mid-FETCH takes effect without a clock edge.
    rst = 1'b1;
    #1;
    chk("mrst_req", 32'(imem_req), 32'd0);
    chk("mrst_addr", imem_addr, 32'h0);
    chk("mrst_valid", 32'(inst_valid), 32'd0);
    chk("mrst_inst", inst, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("mrst_refetch", imem_addr, 32'h0);

    // Three back-to-back instructions, zero ack latency, ready held high.
    inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("seq_req", 32'(imem_req), 32'd1);
      chk("seq_addr_i", imem_addr, 32'(4 * i));
      chk("seq_idle_valid", 32'(inst_valid), 32'd0);
      imem_ack = 1'b1; imem_rdata = words[i];
      tick();
      imem_ack = 1'b0;
      chk("seq_valid_i", 32'(inst_valid), 32'd1);
      chk("seq_pc_i", inst_pc, 32'(4 * i));
      chk("seq_inst_i", inst, words[i]);
      chk("seq_gap_req", 32'(imem_req), 32'd0);
      tick();
    end
    chk("seq_next_addr", imem_addr, 32'hC);

    // Redirect coincident with ack discards data; then check PC wraparound.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
    tick();
    redirect_valid = 1'b0; imem_ack = 1'b0;
    chk("coinc_valid", 32'(inst_valid), 32'd0);
    chk("coinc_addr", imem_addr, 32'hFFFF_FFFC);
    imem_ack = 1'b1; imem_rdata = 32'h0000_0063;
    tick();
    imem_ack = 1'b0;
    chk("wrap_pc", inst_pc, 32'hFFFF_FFFC);
    chk("wrap_opcode", 32'(opcode), 32'h63);
    tick();
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_req", 32'(imem_req), 32'd1);

    // Misaligned redirect faults; fault is sticky and ignores ack/redirect.
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick();
    chk("mis_fault", 32'(fetch_fault), 32'd1);
    chk("mis_req", 32'(imem_req), 32'd0);
    chk("mis_valid", 32'(inst_valid), 32'd0);
    chk("mis_opcode", 32'(opcode), 32'd0);
    imem_ack = 1'b1; redirect_pc = 32'h200;
    tick(); tick(); tick();
    imem_ack = 1'b0; redirect_valid = 1'b0;
    chk("mis_sticky", 32'(fetch_fault), 32'd1);
    chk("mis_sticky_req", 32'(imem_req), 32'd0);

    // Bus error on ack faults; reset clears it.
    rst = 1'b1;
    #1;
    chk("err_rst_fault", 32'(fetch_fault), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("err_fetch_addr", imem_addr, 32'h0);
    imem_ack = 1'b1; imem_err = 1'b1; imem_rdata = 32'h0000_0013;
    tick();
    imem_ack = 1'b0; imem_err = 1'b0;
    chk("err_fault", 32'(fetch_fault), 32'd1);
    chk("err_req", 32'(imem_req), 32'd0);
    chk("err_valid", 32'(inst_valid), 32'd0);
    tick();
    chk("err_sticky", 32'(fetch_fault), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Multicycle instruction fetch stage. Issues word reads to instruction memory through a req/ack handshake and latches the returned word into the instruction register (IR).
- Presents the instruction and its opcode field to the main decoder/control FSM through a valid/ready handshake.
- Accepts PC redirects from branch/jump resolution.
- It is the producer end of the opcode interface the control decoder consumes.

Parameters:
- XLEN, 32: width of PC, addresses and instruction words.
- RESET_PC, 32'h0000_0000: PC value loaded on reset; must be 4-byte aligned.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req  output  1  read request to instruction memory.
- imem_addr  output  XLEN  word-aligned fetch address.
- imem_ack  input  1  one-cycle pulse; imem_rdata/imem_err valid this cycle.
- imem_rdata  input  XLEN  fetched instruction word.
- imem_err  input  1  bus error, sampled only when imem_ack=1.
- inst_valid  output  1  IR holds an instruction for decode.
- inst  output  XLEN  IR contents.
- opcode  output  7  inst[6:0] when inst_valid=1, else 7'b0000000.
- inst_pc  output  XLEN  PC of the instruction in IR.
- inst_ready  input  1  decoder/control consumes the instruction this cycle.
- redirect_valid  input  1  one-cycle pulse: next fetch comes from redirect_pc.
- redirect_pc  input  XLEN  redirect target.
- fetch_fault  output  1  sticky fault indicator.

Behaviour:
- States: IDLE, FETCH, HOLD, FAULT. All outputs are registered or decoded directly from state and registers.
- Reset (async, any cycle, including mid-transaction):
  - state=IDLE, pc=RESET_PC, IR=0, inst_pc=0, redirect_pend=0.
  - imem_req=0, inst_valid=0, opcode=0, fetch_fault=0.
  - Any outstanding memory transaction is abandoned.
- IDLE -> FETCH unconditionally on the first clock after rst deasserts.
- FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until imem_ack. The request is never withdrawn early.
  - On imem_ack with imem_err=1 -> FAULT.
  - On imem_ack with redirect_pend=1 -> discard data, pc<=redirect target, clear redirect_pend, stay in FETCH with a new request the next cycle.
  - On imem_ack otherwise -> IR<=imem_rdata, inst_pc<=pc, go to HOLD.
  - Latency: ack in cycle N -> inst_valid=1 in cycle N+1.
- HOLD:
  - inst_valid=1, imem_req=0. IR, inst_pc and opcode are held stable until inst_ready=1.
  - On inst_ready: pc<=pc+4 (mod 2^XLEN, wraps 0xFFFF_FFFC -> 0), go to FETCH. New request appears the next cycle.
- Redirect handling:
  - redirect_valid is accepted in FETCH or HOLD and ignored in IDLE and FAULT.
  - In HOLD, the redirect target replaces pc+4 whether or not inst_ready is asserted in the same cycle; redirect wins over sequential increment.
  - A redirect in HOLD without inst_ready loads pc but stays in HOLD.
  - In FETCH before ack: target stored, redirect_pend=1.
  - Redirect in the same cycle as ack: treated as pending, so the acked data is discarded.
  - A later redirect overwrites an earlier pending one.
- Misalignment: redirect_pc[1:0] != 0 -> FAULT on the next cycle; any outstanding ack is ignored.
- FAULT:
  - fetch_fault=1, imem_req=0, inst_valid=0, opcode=0.
  - Exit only by reset.
- opcode=0 whenever not valid, so the decoder drives its safe default controls.

Test Plan:
- Reset release with RESET_PC=0, ack after 2 wait cycles with rdata=0x00500093 -> imem_req high from cycle 1 with addr 0x0; inst_valid next cycle after ack; opcode=7'b0010011; inst_pc=0x0.
- Consume three instructions with inst_ready held high and ack latency 0 -> addresses 0x0, 0x4, 0x8; each inst_valid lasts exactly 1 cycle; one idle cycle between ack and next req.
- Hold inst_ready=0 for 5 cycles in HOLD -> inst, opcode, inst_pc unchanged; imem_req=0.
- Redirect to 0x100 while waiting for ack at 0x4 -> acked word dropped (inst_valid stays 0), next request addr=0x100.
- In HOLD assert redirect_valid=1 (target 0x40) and inst_ready=1 together -> next imem_addr=0x40, not pc+4.
- Redirect to 0x102, or imem_err=1 on ack -> fetch_fault=1 the next cycle, imem_req=0, stays until rst. Assert rst mid-FETCH -> all outputs to 0 immediately, refetch from RESET_PC.
